// File: rtl/fifo_tile_reader.sv
// fifo_tile_reader
// Drains a tile of tile_len words from a synchronous FIFO with one cycle of
// read latency and streams them out as valid/ready with a last-word marker.
// A 2-entry output buffer with credit-based read issue sustains one word per
// cycle while never overflowing.
// Optional build macro: FIFO_TILE_READER_STATS_EN adds a 16-bit saturating
// stall_cnt output counting RUN cycles starved by an empty FIFO.
module fifo_tile_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  tile_len,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef FIFO_TILE_READER_STATS_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  zero_tile_q;
  logic [LEN_WIDTH-1:0]  len_q;

  logic [LEN_WIDTH-1:0]  issued_q;
  logic [LEN_WIDTH-1:0]  issued_d;
  logic [LEN_WIDTH-1:0]  accepted_q;
  logic [LEN_WIDTH-1:0]  accepted_d;
  logic [1:0]            occ_q;
  logic [1:0]            occ_d;
  logic                  head_q;
  logic                  head_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] buf_q [2];

  logic                  start_accept;
  logic                  push;
  logic                  pop;
  logic                  tail_idx;
  logic                  rd_en;
  logic [2:0]            credit_sum;

  // A start is only honoured when no tile is in progress.
  assign start_accept = (state_q == S_IDLE) && start;

  // Data returned by last cycle's read lands in the buffer this cycle.
  assign push     = inflight_q;
  assign m_valid  = (occ_q != 2'd0);
  assign pop      = m_valid && m_ready;

  // Slots that will be committed after this edge if no new read is issued.
  assign credit_sum = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign rd_en = (state_q == S_RUN) && !fifo_empty &&
                 (issued_q < len_q) && (credit_sum < 3'd2);
  assign fifo_r_en = rd_en;

  // Tail slot is head + occupancy modulo 2; with occ = 2 and a pop this is
  // the slot being freed, which is exactly where the new word belongs.
  assign tail_idx = head_q ^ occ_q[0];

  assign m_data = buf_q[head_q];
  // The head word's index within the tile equals the number already accepted.
  assign m_last = m_valid && (accepted_q == (len_q - LEN_ONE));

  assign busy = busy_q;
  assign done = done_q;

  // Next-state for the issue/accept counters and buffer pointers.
  always_comb begin
    issued_d   = issued_q + (rd_en ? LEN_ONE : '0);
    accepted_d = accepted_q + (pop ? LEN_ONE : '0);
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    head_d     = head_q ^ pop;
    if (start_accept) begin
      issued_d   = '0;
      accepted_d = '0;
    end
  end

  // Counter, occupancy and in-flight tracking; reset drops any pending read.
  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q   <= '0;
      accepted_q <= '0;
      occ_q      <= 2'd0;
      head_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      inflight_q <= rd_en;
    end
  end

  // Output buffer storage: capture returning FIFO data at the tail slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        buf_q[i] <= '0;
      end
    end else if (push) begin
      buf_q[tail_idx] <= fifo_data_out;
    end
  end

  // Tile sequencing FSM with registered busy/done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      zero_tile_q <= 1'b0;
      len_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q       <= tile_len;
            busy_q      <= 1'b1;
            zero_tile_q <= (tile_len == '0);
            state_q     <= (tile_len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (issued_d == len_q) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Leave once the final word has been accepted and nothing returns.
          if (occ_d == 2'd0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          // An empty tile has no drained word to mark, so its pulse trails
          // its single busy cycle.
          done_q      <= zero_tile_q;
          zero_tile_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_TILE_READER_STATS_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of RUN cycles that wanted a word but found the FIFO empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else if (start_accept) begin
      stall_cnt_q <= 16'd0;
    end else if ((state_q == S_RUN) && (issued_q < len_q) && fifo_empty &&
                 (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/fifo_tile_reader.md
# fifo_tile_reader

Drains a fixed-length tile of words from a synchronous FIFO and presents them downstream as a valid/ready stream with a last-word marker. Sits directly on the read side of a sync FIFO, driving its `r_en` and consuming its `data_out`, `empty` outputs. Feeds the systolic-array row loaders. Hides the FIFO's one-cycle read latency behind a 2-entry output buffer and sustains one word per cycle.

## Interface
- `DATA_WIDTH`, 16, word width; matches the FIFO data width.
- `LEN_WIDTH`, 8, width of the tile-length field; max tile = 2^LEN_WIDTH − 1 words.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: begin a tile; sampled only in IDLE.
- `tile_len` in LEN_WIDTH: words to read; sampled with `start`.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the last word is accepted downstream.
- `fifo_r_en` out 1: FIFO read enable.
- `fifo_data_out` in DATA_WIDTH: FIFO read data, valid the cycle after `fifo_r_en`.
- `fifo_empty` in 1: FIFO empty flag.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: downstream ready.
- `m_data` out DATA_WIDTH: output word.
- `m_last` out 1: high with the final word of the tile.

## Operation
- States:
  - IDLE: on `start`, latch `tile_len` into `remaining`, clear `issued`, go to RUN. If `tile_len` == 0, go to DONE instead.
  - RUN: issue reads until `issued` == latched length, then go to DRAIN.
  - DRAIN: wait until the buffer is empty and no read is in flight, then go to DONE.
  - DONE: pulse `done` for one cycle, then return to IDLE.
- Read issue rule: `fifo_r_en` = RUN && !`fifo_empty` && `issued` < len && (occ + inflight − pop) < 2.
  - occ: buffer occupancy, 0..2.
  - inflight: registered `fifo_r_en` from the previous cycle.
  - pop: `m_valid` && `m_ready`.
- Returned data: `fifo_data_out` is written into the buffer tail in the cycle where inflight = 1. The credit rule guarantees the buffer never overflows.
- Output: `m_data` and `m_valid` come from the buffer head. `m_valid` holds, and `m_data` stays stable, until accepted.
- `m_last` = `m_valid` && head word index == len − 1. A word counter counts accepted words.
- `start` while `busy` is ignored. `tile_len` is not re-sampled mid-tile.
- Arithmetic: `issued` and `accepted` counters are LEN_WIDTH bits and never wrap, since they stop at len.
- Simultaneous push and pop with occ = 2: legal. Occupancy stays 2.

## Timing
- Reset values: `busy`, `done`, `fifo_r_en`, `m_valid` and `m_last` are 0; `m_data` is 0; state is IDLE; buffer is empty. Reset also discards any in-flight read.
- Reset mid-tile: the next cycle is IDLE with all outputs at reset values. No `done` pulse is issued.
- `start` high in cycle k: `busy` is high from k+1. The first `fifo_r_en` can occur in k+1. The first `m_valid` appears in k+3.
- With `m_ready` held high and the FIFO non-empty, the block reads and emits one word per cycle.
- After a tile of N words with no stalls: the last word is accepted in k+2+N, `done` pulses in k+3+N, and `busy` drops in k+4+N.
- `tile_len` = 0: `done` in k+2, no `fifo_r_en`, no `m_valid`.
- `fifo_empty` is checked in the same cycle as `fifo_r_en`. A read is never issued while empty.

## Configuration
- `FIFO_TILE_READER_STATS_EN` defined:
  - Adds output `stall_cnt` (16 bits).
  - Counts RUN cycles in which `issued` < len && `fifo_empty`.
  - Saturates at 0xFFFF.
  - Cleared on accepted `start` and on `rst`.
- Undefined: no port and no counter logic. All other behaviour is identical.

## Test plan
- Reset, then `start` with `tile_len`=4, FIFO preloaded with 0x11,0x22,0x33,0x44, `m_ready`=1:
  - Words out in order in cycles k+3..k+6.
  - `m_last` high only with 0x44.
  - `done` in k+7.
- `tile_len`=0 -> no `fifo_r_en`, no `m_valid`, `done` in k+2, `busy` high for one cycle only.
- `tile_len`=8, `m_ready` toggling 1,0,0,1 repeatedly:
  - `fifo_r_en` never makes occ exceed 2.
  - `m_data` stable while `m_valid` && !`m_ready`.
  - All 8 words are delivered in order.
- `tile_len`=6, FIFO empty for 5 cycles mid-tile:
  - No `fifo_r_en` while empty.
  - Stream resumes with no word lost.
  - With STATS_EN, `stall_cnt` = 5.
- `tile_len`=10 with `rst` asserted after 3 words are accepted:
  - Next cycle all outputs are 0 and state is IDLE, with no `done`.
  - A new `start` with `tile_len`=2 works normally.
- `start` re-asserted while `busy` -> ignored; the original tile completes with a single `done`.
